magia_tile_launch_ctrl: RTL and testbench

- Parametrised successor to the single-RedMulE-tile fixture drive logic; synthesizable.
- Sequences enable, boot and fetch-enable for N_TILES RedMulE tiles, with staggered core launch to limit inrush and instruction-memory contention.
- Collects per-tile end-of-computation events and busy status. Reports completion, timeout and a cycle count.
- Sits between the mesh-level control register file and the tile array.

---
 rtl/magia_tile_launch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_magia_tile_launch_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_tile_launch_ctrl.sv
// Purpose     : enables, boots and launches N_TILES RedMulE tiles with staggered fetch-enable;
//               collects EOC/busy and reports done, timeout and a LAUNCH/RUN cycle count.
// Latency     : tile_enable_o 1 cycle after an accepted start, first fetch_enable_o 2 cycles after.
// Backpressure: none; start_i is dropped while a launch is in flight, abort_i always wins.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   start_i, abort_i         launch request (IDLE/DONE/TOUT), synchronous abort (any state)
//   tile_mask_i, timeout_i   tiles to launch and timeout (0 = off); latched on accepted start
//   tile_busy_i, tile_eoc_i  per-tile busy level and end-of-computation pulse
//   tile_enable_o            per-tile enable, set from ENABLE onwards
//   fetch_enable_o           per-tile fetch enable, staggered by STAGGER_CYCLES
//   boot_addr_o, mhartid_o   constant boot address and per-tile hart id
//   eoc_mask_o               sticky EOCs seen from launched tiles
//   done_o, timeout_o        completion / timeout levels
//   cycles_o                 saturating cycle count since LAUNCH entry

module magia_tile_launch_ctrl #(
    parameter int unsigned N_TILES        = 4,
    parameter logic [31:0] BOOT_ADDR      = 32'h0000_0080,
    parameter logic [31:0] HARTID_BASE    = 32'd0,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [N_TILES-1:0]       tile_mask_i,
    input  logic [CNT_W-1:0]         timeout_i,
    input  logic [N_TILES-1:0]       tile_busy_i,
    input  logic [N_TILES-1:0]       tile_eoc_i,
    output logic [N_TILES-1:0]       tile_enable_o,
    output logic [N_TILES-1:0]       fetch_enable_o,
    output logic [31:0]              boot_addr_o,
    output logic [N_TILES-1:0][31:0] mhartid_o,
    output logic [N_TILES-1:0]       eoc_mask_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [CNT_W-1:0]         cycles_o
);

    localparam int unsigned       STAG_W      = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [STAG_W-1:0] STAG_RELOAD = STAG_W'(STAGGER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENABLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t             state_q, state_d;
    logic [N_TILES-1:0] mask_q, mask_d;
    logic [N_TILES-1:0] tile_en_q, tile_en_d;
    logic [N_TILES-1:0] fetch_q, fetch_d;
    logic [N_TILES-1:0] eoc_q, eoc_d;
    logic [CNT_W-1:0]   timeout_q, timeout_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [STAG_W-1:0]  stag_q, stag_d;

    logic [N_TILES-1:0] pending;
    logic [N_TILES-1:0] next_tile;
    logic [N_TILES-1:0] eoc_all;
    logic               all_done;
    logic               tout_hit;
    logic [CNT_W-1:0]   cycles_inc;

    // Masked tiles not yet launched; the lowest set bit is the next one to start.
    assign pending    = mask_q & ~fetch_q;
    assign next_tile  = pending & (~pending + N_TILES'(1));
    // Completion looks at this cycle's EOCs too, so a last EOC coinciding
    // with the timeout cycle still ends in DONE.
    assign eoc_all    = eoc_q | (tile_eoc_i & fetch_q);
    assign all_done   = (eoc_all == mask_q) && ((tile_busy_i & mask_q) == '0);
    assign tout_hit   = (timeout_q != '0) && (cycles_q == timeout_q);
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        tile_en_d = tile_en_q;
        fetch_d   = fetch_q;
        eoc_d     = eoc_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        stag_d    = stag_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start_i) begin
                    mask_d    = tile_mask_i;
                    timeout_d = timeout_i;
                    tile_en_d = tile_mask_i;
                    fetch_d   = '0;
                    eoc_d     = '0;
                    state_d   = (tile_mask_i == '0) ? S_DONE : S_ENABLE;
                end
            end
            S_ENABLE: begin
                fetch_d  = next_tile;
                stag_d   = STAG_RELOAD;
                cycles_d = '0;
                state_d  = S_LAUNCH;
            end
            S_LAUNCH: begin
                cycles_d = cycles_inc;
                eoc_d    = eoc_all;
                if (tout_hit) begin
                    fetch_d = '0;
                    state_d = S_TOUT;
                end else if (pending == '0) begin
                    state_d = S_RUN;
                end else if (stag_q == '0) begin
                    fetch_d = fetch_q | next_tile;
                    stag_d  = STAG_RELOAD;
                end else begin
                    stag_d = stag_q - STAG_W'(1);
                end
            end
            S_RUN: begin
                cycles_d = cycles_inc;
                eoc_d    = eoc_all;
                if (all_done) begin
                    state_d = S_DONE;
                end else if (tout_hit) begin
                    fetch_d = '0;
                    state_d = S_TOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d   = S_IDLE;
            mask_d    = '0;
            tile_en_d = '0;
            fetch_d   = '0;
            eoc_d     = '0;
            timeout_d = '0;
            cycles_d  = '0;
            stag_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            tile_en_q <= '0;
            fetch_q   <= '0;
            eoc_q     <= '0;
            timeout_q <= '0;
            cycles_q  <= '0;
            stag_q    <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            tile_en_q <= tile_en_d;
            fetch_q   <= fetch_d;
            eoc_q     <= eoc_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
            stag_q    <= stag_d;
        end
    end

    assign tile_enable_o  = tile_en_q;
    assign fetch_enable_o = fetch_q;
    assign eoc_mask_o     = eoc_q;
    assign done_o         = (state_q == S_DONE);
    assign timeout_o      = (state_q == S_TOUT);
    assign cycles_o       = cycles_q;
    assign boot_addr_o    = BOOT_ADDR;

    for (genvar i = 0; i < N_TILES; i++) begin : g_hartid
        assign mhartid_o[i] = HARTID_BASE + 32'(i);
    end

endmodule

// File: tb/tb_magia_tile_launch_ctrl.sv
// Purpose     : self-checking bench for magia_tile_launch_ctrl against a schedule-based model.
// Latency     : outputs compared every cycle on the falling edge.
// Backpressure: none; stimulus is driven on the falling edge.

module tb_magia_tile_launch_ctrl;

    localparam int          N     = 4;
    localparam int          S     = 4;
    localparam int          CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam logic [31:0] BOOT  = 32'h0000_0080;
    localparam logic [31:0] HBASE = 32'd16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              abort;
    logic [N-1:0]      tile_mask;
    logic [CW-1:0]     timeout;
    logic [N-1:0]      tile_busy;
    logic [N-1:0]      tile_eoc;
    logic [N-1:0]      tile_enable;
    logic [N-1:0]      fetch_enable;
    logic [31:0]       boot_addr;
    logic [N-1:0][31:0] mhartid;
    logic [N-1:0]      eoc_mask;
    logic              done;
    logic              tout;
    logic [CW-1:0]     cycles;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the launch is described by its start cycle and mask,
    // and every output is derived from the launch schedule arithmetic.
    logic [N-1:0]  m_ten, m_fen, m_eoc, m_mask;
    logic          m_done, m_tout, m_active;
    logic [CW-1:0] m_cycles, m_to;
    int            m_t0;

    logic [3*N+2+CW-1:0] obs, mdl;
    assign obs = {tile_enable, fetch_enable, eoc_mask, done, tout, cycles};
    assign mdl = {m_ten, m_fen, m_eoc, m_done, m_tout, m_cycles};

    magia_tile_launch_ctrl #(
        .N_TILES       (N),
        .BOOT_ADDR     (BOOT),
        .HARTID_BASE   (HBASE),
        .STAGGER_CYCLES(S),
        .CNT_W         (CW)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .start_i       (start),
        .abort_i       (abort),
        .tile_mask_i   (tile_mask),
        .timeout_i     (timeout),
        .tile_busy_i   (tile_busy),
        .tile_eoc_i    (tile_eoc),
        .tile_enable_o (tile_enable),
        .fetch_enable_o(fetch_enable),
        .boot_addr_o   (boot_addr),
        .mhartid_o     (mhartid),
        .eoc_mask_o    (eoc_mask),
        .done_o        (done),
        .timeout_o     (tout),
        .cycles_o      (cycles)
    );

    always #5 clk = ~clk;

    function automatic int popc(input logic [N-1:0] m);
        int n = 0;
        for (int i = 0; i < N; i++) if (m[i]) n++;
        return n;
    endfunction

    // Tile i launches at t0 + 2 + (number of masked tiles below i) * S.
    function automatic logic [N-1:0] sched(input logic [N-1:0] m, input int t0, input int c);
        logic [N-1:0] f = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i] && c >= t0 + 2 + popc(m & N'((1 << i) - 1)) * S) f[i] = 1'b1;
        end
        return f;
    endfunction

    task automatic model_reset();
        m_ten = '0; m_fen = '0; m_eoc = '0; m_mask = '0;
        m_done = 1'b0; m_tout = 1'b0; m_active = 1'b0;
        m_cycles = '0; m_to = '0; m_t0 = 0;
    endtask

    // Advance the model over the current cycle using the inputs driven in it.
    task automatic model_step();
        int           last;
        int           cnt;
        logic [N-1:0] eoc_new;
        if (abort) begin
            model_reset();
        end else if (!m_active && start) begin
            m_t0 = cyc; m_mask = tile_mask; m_to = timeout; m_ten = tile_mask;
            m_fen = '0; m_eoc = '0; m_tout = 1'b0;
            m_done = (tile_mask == '0); m_active = (tile_mask != '0);
        end else if (m_active && cyc >= m_t0 + 2) begin
            last    = m_t0 + 2 + (popc(m_mask) - 1) * S;
            eoc_new = m_eoc | (tile_eoc & m_fen);
            cnt     = cyc + 1 - (m_t0 + 2);
            if (cnt > CMAX) cnt = CMAX;
            if (cyc > last && eoc_new == m_mask && (tile_busy & m_mask) == '0) begin
                m_done = 1'b1; m_active = 1'b0;
            end else if (m_to != '0 && m_cycles == m_to) begin
                m_tout = 1'b1; m_active = 1'b0; m_fen = '0;
            end else begin
                m_fen = sched(m_mask, m_t0, cyc + 1);
            end
            m_eoc = eoc_new;
            m_cycles = CW'(cnt);
        end else if (m_active) begin
            m_fen = sched(m_mask, m_t0, cyc + 1);
            m_cycles = '0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 1'b0; abort = 1'b0; tile_eoc = '0; tile_busy = '0;
    endtask

    task automatic test_reset();
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        total++;
        if (boot_addr !== BOOT) begin
            bad++; $display("FAIL reset_boot_addr got=%h exp=%h", boot_addr, BOOT);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (mhartid[i] !== HBASE + 32'(i)) begin
                bad++; $display("FAIL mhartid[%0d] got=%0d exp=%0d", i, mhartid[i], HBASE + 32'(i));
            end
        end
    endtask

    task automatic test_full_launch();
        int t0 = cyc;
        int first_done = -1;
        int rise[N];
        for (int i = 0; i < N; i++) rise[i] = -1;
        tile_mask = 4'hF; timeout = '0;
        for (int r = 0; r < 30; r++) begin
            start     = (r == 0);
            tile_eoc  = (r >= 20 && r <= 23) ? N'(1 << (r - 20)) : '0;
            tile_busy = (r < 24) ? 4'hF : 4'h0;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL full_launch cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (done && first_done < 0) first_done = cyc - t0;
            for (int i = 0; i < N; i++) if (fetch_enable[i] && rise[i] < 0) rise[i] = cyc - t0;
        end
        clear_inputs();
        for (int i = 0; i < N; i++) begin
            total++;
            if (rise[i] != 2 + S * i) begin
                bad++; $display("FAIL full_fetch_rise[%0d] got=%0d exp=%0d", i, rise[i], 2 + S * i);
            end
        end
        total++;
        if (first_done != 25) begin
            bad++; $display("FAIL full_done_cycle got=%0d exp=25", first_done);
        end
        total++;
        if (cycles !== 8'd23) begin
            bad++; $display("FAIL full_cycles_frozen got=%0d exp=23", cycles);
        end
    endtask

    task automatic test_sparse_mask();
        int t0 = cyc;
        int first_done = -1;
        tile_mask = 4'b1010; timeout = '0;
        for (int r = 0; r < 14; r++) begin
            start    = (r == 0);
            tile_eoc = (r == 3) ? 4'b0001 : (r == 8) ? 4'b0010 : (r == 10) ? 4'b1000 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL sparse cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (cyc - t0 == 2) begin
                total++;
                if (fetch_enable !== 4'b0010) begin
                    bad++; $display("FAIL sparse_first_fetch got=%b exp=0010", fetch_enable);
                end
            end
            if (done && first_done < 0) first_done = cyc - t0;
        end
        clear_inputs();
        total++;
        if (eoc_mask !== 4'b1010 || fetch_enable !== 4'b1010) begin
            bad++; $display("FAIL sparse_final eoc=%b fen=%b exp=1010/1010", eoc_mask, fetch_enable);
        end
        total++;
        if (first_done != 11) begin
            bad++; $display("FAIL sparse_done_cycle got=%0d exp=11", first_done);
        end
    endtask

    task automatic test_timeout();
        int t0 = cyc;
        int first_tout = -1;
        tile_mask = 4'hF; timeout = 8'd20;
        for (int r = 0; r < 28; r++) begin
            start     = (r == 0);
            tile_busy = 4'b0100;
            tile_eoc  = (r == 5) ? 4'b0001 : (r == 8) ? 4'b0010 : (r == 16) ? 4'b1000 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (tout && first_tout < 0) first_tout = cyc - t0;
        end
        clear_inputs();
        total++;
        if (first_tout != 23) begin
            bad++; $display("FAIL timeout_cycle got=%0d exp=23", first_tout);
        end
        total++;
        if (fetch_enable !== 4'h0 || tile_enable !== 4'hF || eoc_mask !== 4'b1011 || done !== 1'b0) begin
            bad++; $display("FAIL timeout_hold fen=%b ten=%b eoc=%b done=%b exp=0000/1111/1011/0",
                            fetch_enable, tile_enable, eoc_mask, done);
        end
    endtask

    task automatic test_tie();
        int t0 = cyc;
        int first_done = -1;
        int saw_tout = 0;
        tile_mask = 4'b0001; timeout = 8'd10;
        for (int r = 0; r < 16; r++) begin
            start    = (r == 0);
            tile_eoc = (r == 12) ? 4'b0001 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL tie cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (done && first_done < 0) first_done = cyc - t0;
            if (tout) saw_tout++;
        end
        clear_inputs();
        total++;
        if (first_done != 13 || saw_tout != 0) begin
            bad++; $display("FAIL tie_result done_at=%0d tout_cycles=%0d exp=13/0", first_done, saw_tout);
        end
    endtask

    task automatic test_abort();
        int t0 = cyc;
        tile_mask = 4'hF; timeout = '0;
        for (int r = 0; r < 10; r++) begin
            start     = (r == 0);
            abort     = (r == 7);
            tile_busy = 4'hF;
            tile_eoc  = (r == 4) ? 4'b0001 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL abort cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (cyc - t0 == 7) begin
                total++;
                if (fetch_enable !== 4'b0011 || eoc_mask !== 4'b0001) begin
                    bad++; $display("FAIL abort_pre fen=%b eoc=%b exp=0011/0001", fetch_enable, eoc_mask);
                end
            end
            if (cyc - t0 == 8) begin
                total++;
                if (obs !== '0) begin
                    bad++; $display("FAIL abort_clear got=%h exp=0", obs);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_zero_mask();
        int t0 = cyc;
        tile_mask = 4'h0; timeout = '0;
        for (int r = 0; r < 3; r++) begin
            start = (r == 0);
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL zero_mask cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (cyc - t0 == 1) begin
                total++;
                if (done !== 1'b1 || tile_enable !== 4'h0 || fetch_enable !== 4'h0) begin
                    bad++; $display("FAIL zero_mask_done done=%b ten=%b fen=%b exp=1/0000/0000",
                                    done, tile_enable, fetch_enable);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_start_ignored();
        int t0 = cyc;
        int first_done = -1;
        timeout = '0;
        for (int r = 0; r < 18; r++) begin
            tile_mask = (r == 0) ? 4'b0011 : (r == 4) ? 4'b1111 : 4'b1100;
            start     = (r == 0) || (r == 4) || (r == 9);
            tile_busy = (r < 14) ? 4'b0011 : 4'b0000;
            tile_eoc  = (r == 12) ? 4'b0001 : (r == 13) ? 4'b0010 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL start_ignored cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            total++;
            if (tile_enable !== 4'b0011) begin
                bad++; $display("FAIL start_ignored_ten cyc=%0d got=%b exp=0011", cyc - t0, tile_enable);
            end
            if (done && first_done < 0) first_done = cyc - t0;
        end
        clear_inputs();
        total++;
        if (first_done != 15) begin
            bad++; $display("FAIL start_ignored_done got=%0d exp=15", first_done);
        end
    endtask

    task automatic test_reset_midrun();
        int t0 = cyc;
        tile_mask = 4'hF; timeout = '0;
        for (int r = 0; r < 18; r++) begin
            start     = (r == 0);
            tile_busy = 4'hF;
            tile_eoc  = (r == 16) ? 4'b0001 : 4'b0000;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL midrun cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
        end
        clear_inputs();
        rstn = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== '0 || boot_addr !== BOOT) begin
            bad++; $display("FAIL midrun_async_reset got=%h boot=%h exp=0/%h", obs, boot_addr, BOOT);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL midrun_reset_hold got=%h exp=0", obs);
        end
        rstn = 1'b1;
    endtask

    task automatic test_saturation();
        int t0 = cyc;
        tile_mask = 4'b0001; timeout = '0;
        for (int r = 0; r < 271; r++) begin
            start     = (r == 0);
            abort     = (r == 270);
            tile_busy = 4'b0001;
            tick();
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL saturation cyc=%0d got=%h exp=%h", cyc - t0, obs, mdl);
            end
            if (r == 269) begin
                total++;
                if (cycles !== 8'hFF) begin
                    bad++; $display("FAIL saturation_value got=%0d exp=255", cycles);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 50; r++) begin
                tile_mask = N'($urandom_range(0, 15));
                timeout   = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(3, 40));
                start     = (r == 0) || ($urandom_range(0, 30) == 0);
                abort     = ($urandom_range(0, 60) == 0);
                for (int i = 0; i < N; i++) tile_eoc[i] = ($urandom_range(0, 4) == 0);
                tile_busy = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
                tick();
                total++;
                if (obs !== mdl) begin
                    bad++; $display("FAIL random round=%0d step=%0d got=%h exp=%h", k, r, obs, mdl);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        tile_mask = '0;
        timeout = '0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_full_launch();
        test_sparse_mask();
        test_timeout();
        test_tie();
        test_abort();
        test_zero_mask();
        test_start_ignored();
        test_reset_midrun();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
